// File: rtl/riscv_pkg.sv
// Shared encoding constants for the two-stage pipelined core.
package riscv_pkg;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_ADDI = 3'b010;
    localparam logic [2:0] OP_LUI  = 3'b011;
    localparam logic [2:0] OP_AND  = 3'b100;
    localparam logic [2:0] OP_XOR  = 3'b101;
    localparam logic [2:0] OP_BNZ  = 3'b110;
    localparam logic [2:0] OP_HALT = 3'b111;

    // Flags are packed as {N,Z,C,V}
    localparam int FLAG_V = 0;
    localparam int FLAG_C = 1;
    localparam int FLAG_Z = 2;
    localparam int FLAG_N = 3;

    // Instruction field positions (least significant bit of each field)
    localparam int OP_LSB    = 13;
    localparam int RD_LSB    = 10;
    localparam int RS1_LSB   = 7;
    localparam int RS2_LSB   = 0;
    localparam int IMM7_LSB  = 0;
    localparam int IMM10_LSB = 0;

    // Everything except branch and halt produces a register result
    function automatic logic writesReg(input logic [2:0] op);
        return (op != OP_BNZ) && (op != OP_HALT);
    endfunction

endpackage

// File: rtl/riscv_exec_alu.sv
// Combinational execute-stage ALU: result and next flag state for one instruction.
module riscv_exec_alu
    import riscv_pkg::*;
#(
    parameter int L = 16
) (
    input  logic [2:0]   op,
    input  logic [L-1:0] a,
    input  logic [L-1:0] b,
    input  logic [3:0]   flagsIn,
    output logic [L-1:0] result,
    output logic [3:0]   flagsOut
);

    logic [L:0] sum;
    logic [L:0] diff;
    logic       updateNZ;

    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} - {1'b0, b};

    // Select the operation result; flags not touched by the opcode keep their old value
    always_comb begin
        result   = '0;
        flagsOut = flagsIn;
        updateNZ = 1'b0;
        case (op)
            OP_ADD, OP_ADDI: begin
                result           = sum[L-1:0];
                updateNZ         = 1'b1;
                flagsOut[FLAG_C] = sum[L];
                flagsOut[FLAG_V] = (a[L-1] == b[L-1]) && (sum[L-1] != a[L-1]);
            end
            OP_SUB: begin
                result           = diff[L-1:0];
                updateNZ         = 1'b1;
                flagsOut[FLAG_C] = ~diff[L];
                flagsOut[FLAG_V] = (a[L-1] != b[L-1]) && (diff[L-1] != a[L-1]);
            end
            OP_LUI: begin
                result = b;
            end
            OP_AND: begin
                result           = a & b;
                updateNZ         = 1'b1;
                flagsOut[FLAG_C] = 1'b0;
                flagsOut[FLAG_V] = 1'b0;
            end
            OP_XOR: begin
                result           = a ^ b;
                updateNZ         = 1'b1;
                flagsOut[FLAG_C] = 1'b0;
                flagsOut[FLAG_V] = 1'b0;
            end
            default: begin
            end
        endcase
        if (updateNZ) begin
            flagsOut[FLAG_N] = result[L-1];
            flagsOut[FLAG_Z] = (result == '0);
        end
    end

endmodule

// File: rtl/riscv_pipe_core.sv
// Two-stage (Fetch / Execute) pipelined core with handshaked instruction fetch,
// BNZ with one-slot flush, HALT and a retired-instruction counter.
module riscv_pipe_core
    import riscv_pkg::*;
#(
    parameter int L          = 16,
    parameter int A          = 3,
    parameter int CountWidth = 32
) (
    input  logic                  Clk,
    input  logic                  Reset,
    output logic [L-1:0]          IAddr,
    output logic                  IReq,
    input  logic                  IValid,
    input  logic [15:0]           IData,
    output logic [8*L-1:0]        DebugData,
    output logic [3:0]            Flags,
    output logic                  Halted,
    output logic [CountWidth-1:0] RetireCount
);

    localparam int NumRegs = 1 << A;

    if (A != 3) begin : gBadA
        $error("riscv_pipe_core: A must be 3, the encoding has 3-bit register fields");
    end
    if (L < 16) begin : gBadL
        $error("riscv_pipe_core: L must be at least 16");
    end

    logic [L-1:0]          pc;
    logic [15:0]           ir;
    logic [L-1:0]          irPc;
    logic                  irValid;
    logic [3:0]            flags;
    logic                  halted;
    logic [CountWidth-1:0] retireCount;
    logic [L-1:0]          regFile [NumRegs];

    logic [2:0]   op;
    logic [A-1:0] rd;
    logic [A-1:0] rs1;
    logic [A-1:0] rs2;
    logic [6:0]   imm7;
    logic [9:0]   imm10;
    logic [L-1:0] imm7Ext;
    logic [L-1:0] luiImm;
    logic [L-1:0] opB;
    logic [L-1:0] aluResult;
    logic [3:0]   aluFlags;
    logic [L-1:0] branchTarget;
    logic         accept;
    logic         branchTaken;
    logic         haltNow;

    assign op      = ir[OP_LSB +: 3];
    assign rd      = ir[RD_LSB +: A];
    assign rs1     = ir[RS1_LSB +: A];
    assign rs2     = ir[RS2_LSB +: A];
    assign imm7    = ir[IMM7_LSB +: 7];
    assign imm10   = ir[IMM10_LSB +: 10];
    assign imm7Ext = {{(L-7){imm7[6]}}, imm7};
    assign luiImm  = {imm10, {(L-10){1'b0}}};

    // Decode the execute-stage instruction: second operand, branch and halt conditions
    always_comb begin
        opB          = regFile[rs2];
        branchTaken  = 1'b0;
        haltNow      = 1'b0;
        branchTarget = irPc + imm7Ext;
        if (op == OP_ADDI) begin
            opB = imm7Ext;
        end else if (op == OP_LUI) begin
            opB = luiImm;
        end
        if (irValid) begin
            branchTaken = (op == OP_BNZ) && !flags[FLAG_Z];
            haltNow     = (op == OP_HALT);
        end
    end

    riscv_exec_alu #(.L(L)) uAlu (
        .op       (op),
        .a        (regFile[rs1]),
        .b        (opB),
        .flagsIn  (flags),
        .result   (aluResult),
        .flagsOut (aluFlags)
    );

    // Fetch requests run whenever the core is neither in reset nor halted
    always_comb begin
        IReq   = !Reset && !halted;
        accept = IReq && IValid;
    end

    // Pipeline state: commit the executing instruction, then refill or redirect fetch
    always_ff @(posedge Clk) begin
        if (Reset) begin
            pc          <= '0;
            ir          <= '0;
            irPc        <= '0;
            irValid     <= 1'b0;
            flags       <= '0;
            halted      <= 1'b0;
            retireCount <= '0;
            for (int i = 0; i < NumRegs; i++) begin
                regFile[i] <= '0;
            end
        end else if (!halted) begin
            if (irValid) begin
                retireCount <= retireCount + CountWidth'(1);
                flags       <= aluFlags;
                if (writesReg(op) && (rd != '0)) begin
                    regFile[rd] <= aluResult;
                end
            end
            if (haltNow) begin
                halted  <= 1'b1;
                irValid <= 1'b0;
            end else if (branchTaken) begin
                pc      <= branchTarget;
                irValid <= 1'b0;
            end else if (accept) begin
                ir      <= IData;
                irPc    <= pc;
                irValid <= 1'b1;
                pc      <= pc + L'(1);
            end else begin
                irValid <= 1'b0;
            end
        end
    end

    // Expose architectural state, r7 in the top slice down to r0 in the bottom
    always_comb begin
        DebugData = '0;
        for (int i = 0; i < NumRegs; i++) begin
            DebugData[i*L +: L] = regFile[i];
        end
    end

    assign IAddr       = pc;
    assign Flags       = flags;
    assign Halted      = halted;
    assign RetireCount = retireCount;

endmodule

// File: tb/tb_riscv_pipe_core.sv
// Directed bench for riscv_pipe_core with a queue-based scoreboard of expected values.
module tb_riscv_pipe_core;
    import riscv_pkg::*;

    localparam int L = 16;

    logic          Clk = 1'b0;
    logic          Reset;
    logic          IValid;
    logic [15:0]   IData;
    logic [L-1:0]  IAddr;
    logic          IReq;
    logic [8*L-1:0] DebugData;
    logic [3:0]    Flags;
    logic          Halted;
    logic [31:0]   RetireCount;

    logic [15:0]   mem [256];

    int vectors     = 0;
    int miscompares = 0;

    string        tagQ [$];
    logic [127:0] valQ [$];

    riscv_pipe_core #(.L(L), .A(3), .CountWidth(32)) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .IAddr       (IAddr),
        .IReq        (IReq),
        .IValid      (IValid),
        .IData       (IData),
        .DebugData   (DebugData),
        .Flags       (Flags),
        .Halted      (Halted),
        .RetireCount (RetireCount)
    );

    // Free-running clock
    always #5 Clk = ~Clk;

    // Instruction memory model, read combinationally at the fetch address
    assign IData = mem[IAddr[7:0]];

    function automatic logic [15:0] encR(input logic [2:0] op, input logic [2:0] rd,
                                         input logic [2:0] rs1, input logic [2:0] rs2);
        return {op, rd, rs1, 4'b0000, rs2};
    endfunction

    function automatic logic [15:0] encI(input logic [2:0] op, input logic [2:0] rd,
                                         input logic [2:0] rs1, input logic [6:0] imm);
        return {op, rd, rs1, imm};
    endfunction

    function automatic logic [15:0] encU(input logic [2:0] rd, input logic [9:0] imm);
        return {OP_LUI, rd, imm};
    endfunction

    function automatic logic [127:0] regVal(input int r);
        return 128'(DebugData[r*L +: L]);
    endfunction

    task automatic pushExpected(input string tag, input logic [127:0] value);
        tagQ.push_back(tag);
        valQ.push_back(value);
    endtask

    task automatic checkOutput(input logic [127:0] observed);
        string        tag;
        logic [127:0] expected;
        vectors++;
        if (valQ.size() == 0) begin
            miscompares++;
            $display("[TB] FAIL scoreboard_empty: observed %0h required a queued entry", observed);
        end else begin
            tag      = tagQ.pop_front();
            expected = valQ.pop_front();
            assert (observed === expected) else begin
                miscompares++;
                $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
            end
        end
    endtask

    task automatic applyStimulus(input logic valid, input int cycles);
        IValid = valid;
        repeat (cycles) begin
            @(posedge Clk);
            @(negedge Clk);
        end
    endtask

    task automatic loadHalts();
        for (int i = 0; i < 256; i++) begin
            mem[i] = {OP_HALT, 13'b0};
        end
    endtask

    task automatic doReset();
        Reset  = 1'b1;
        IValid = 1'b0;
        @(posedge Clk);
        @(negedge Clk);
        Reset  = 1'b0;
    endtask

    // Watchdog so a stuck run still ends
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed no finish, required finish before timeout");
        $fatal(1, "[TB] timeout");
    end

    // Directed test sequence
    initial begin
        // Reset state and LUI/ADDI
        loadHalts();
        mem[0] = encU(3'd1, 10'd1);
        mem[1] = encI(OP_ADDI, 3'd1, 3'd1, 7'd5);
        pushExpected("rst_ireq",    128'h0);
        pushExpected("rst_iaddr",   128'h0);
        pushExpected("rst_halted",  128'h0);
        pushExpected("rst_retire",  128'h0);
        pushExpected("rst_flags",   128'h0);
        pushExpected("rst_debug",   128'h0);
        pushExpected("t1_r1",       128'h45);
        pushExpected("t1_zflag",    128'h0);
        pushExpected("t1_retire",   128'h2);
        Reset  = 1'b1;
        IValid = 1'b0;
        #1;
        checkOutput(128'(IReq));
        @(posedge Clk);
        @(negedge Clk);
        Reset = 1'b0;
        checkOutput(128'(IAddr));
        checkOutput(128'(Halted));
        checkOutput(128'(RetireCount));
        checkOutput(128'(Flags));
        checkOutput(128'(DebugData));
        applyStimulus(1'b1, 3);
        checkOutput(regVal(1));
        checkOutput(128'(Flags[FLAG_Z]));
        checkOutput(128'(RetireCount));

        // SUB into r0, not-taken BNZ, AND
        loadHalts();
        mem[0] = encU(3'd3, 10'h048);
        mem[1] = encI(OP_ADDI, 3'd3, 3'd3, 7'h34);
        mem[2] = encR(OP_SUB, 3'd0, 3'd3, 3'd3);
        mem[3] = encI(OP_BNZ, 3'd0, 3'd0, 7'h7D);
        mem[4] = encR(OP_AND, 3'd5, 3'd3, 3'd3);
        pushExpected("t2_r0",       128'h0);
        pushExpected("t2_r3",       128'h1234);
        pushExpected("t2_flags",    128'h6);
        pushExpected("t2_retire",   128'h3);
        pushExpected("t2_bnz_addr", 128'h5);
        pushExpected("t2_bnz_ret",  128'h4);
        pushExpected("t2_and_r5",   128'h1234);
        pushExpected("t2_and_flag", 128'h0);
        doReset();
        applyStimulus(1'b1, 4);
        checkOutput(regVal(0));
        checkOutput(regVal(3));
        checkOutput(128'(Flags));
        checkOutput(128'(RetireCount));
        applyStimulus(1'b1, 1);
        checkOutput(128'(IAddr));
        checkOutput(128'(RetireCount));
        applyStimulus(1'b1, 1);
        checkOutput(regVal(5));
        checkOutput(128'(Flags));

        // Signed overflow on ADDI
        loadHalts();
        mem[0] = encU(3'd2, 10'h1FF);
        mem[1] = encI(OP_ADDI, 3'd2, 3'd2, 7'h3F);
        mem[2] = encI(OP_ADDI, 3'd2, 3'd2, 7'h01);
        pushExpected("t3_r2",     128'h8000);
        pushExpected("t3_flags",  128'h9);
        pushExpected("t3_retire", 128'h3);
        doReset();
        applyStimulus(1'b1, 4);
        checkOutput(regVal(2));
        checkOutput(128'(Flags));
        checkOutput(128'(RetireCount));

        // Taken branch flushes one slot
        loadHalts();
        mem[0] = encI(OP_ADDI, 3'd4, 3'd0, 7'd1);
        mem[1] = encI(OP_BNZ,  3'd0, 3'd0, 7'd3);
        mem[2] = encI(OP_ADDI, 3'd5, 3'd0, 7'd7);
        mem[4] = encI(OP_ADDI, 3'd6, 3'd0, 7'd2);
        pushExpected("t4_redirect", 128'h4);
        pushExpected("t4_ret_br",   128'h2);
        pushExpected("t4_r6",       128'h2);
        pushExpected("t4_r5",       128'h0);
        pushExpected("t4_r4",       128'h1);
        pushExpected("t4_retire",   128'h3);
        doReset();
        applyStimulus(1'b1, 3);
        checkOutput(128'(IAddr));
        checkOutput(128'(RetireCount));
        applyStimulus(1'b1, 2);
        checkOutput(regVal(6));
        checkOutput(regVal(5));
        checkOutput(regVal(4));
        checkOutput(128'(RetireCount));

        // Fetch stall holds the address and the machine state
        loadHalts();
        mem[0] = encI(OP_ADDI, 3'd1, 3'd0, 7'd1);
        mem[1] = encI(OP_ADDI, 3'd2, 3'd0, 7'd2);
        pushExpected("t5_addr_a",   128'h1);
        pushExpected("t5_ret_a",    128'h1);
        pushExpected("t5_r1",       128'h1);
        pushExpected("t5_addr_b",   128'h1);
        pushExpected("t5_ret_b",    128'h1);
        pushExpected("t5_r2_stall", 128'h0);
        pushExpected("t5_r2",       128'h2);
        pushExpected("t5_retire",   128'h2);
        pushExpected("t5_halted",   128'h1);
        doReset();
        applyStimulus(1'b1, 1);
        applyStimulus(1'b0, 1);
        checkOutput(128'(IAddr));
        checkOutput(128'(RetireCount));
        checkOutput(regVal(1));
        applyStimulus(1'b0, 2);
        checkOutput(128'(IAddr));
        checkOutput(128'(RetireCount));
        checkOutput(regVal(2));
        applyStimulus(1'b1, 2);
        checkOutput(regVal(2));
        checkOutput(128'(RetireCount));
        applyStimulus(1'b1, 1);
        checkOutput(128'(Halted));

        // HALT freezes the core; reset recovers it
        loadHalts();
        mem[0] = encI(OP_ADDI, 3'd1, 3'd0, 7'd3);
        mem[1] = encI(OP_ADDI, 3'd2, 3'd0, 7'd4);
        mem[2] = encR(OP_XOR,  3'd3, 3'd1, 3'd2);
        mem[4] = encI(OP_ADDI, 3'd7, 3'd0, 7'd9);
        pushExpected("t6_halted",    128'h1);
        pushExpected("t6_ireq",      128'h0);
        pushExpected("t6_retire",    128'h4);
        pushExpected("t6_r3",        128'h7);
        pushExpected("t6_frozen",    128'h4);
        pushExpected("t6_r7",        128'h0);
        pushExpected("t6_rst_halt",  128'h0);
        pushExpected("t6_rst_iaddr", 128'h0);
        pushExpected("t6_rst_debug", 128'h0);
        pushExpected("t6_rst_ret",   128'h0);
        doReset();
        applyStimulus(1'b1, 5);
        checkOutput(128'(Halted));
        checkOutput(128'(IReq));
        checkOutput(128'(RetireCount));
        checkOutput(regVal(3));
        applyStimulus(1'b1, 3);
        checkOutput(128'(RetireCount));
        checkOutput(regVal(7));
        doReset();
        checkOutput(128'(Halted));
        checkOutput(128'(IAddr));
        checkOutput(128'(DebugData));
        checkOutput(128'(RetireCount));

        vectors++;
        assert (valQ.size() == 0) else begin
            miscompares++;
            $error("[TB] FAIL scoreboard_drain: observed %0d entries left, expected 0", valQ.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
